// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding, bus width defaults, round-robin slot helper.
// Pure declarations, no latency. No handshake.
// Also used by the APB register slave, so keep the widths generic.
package apb_pkg;

    localparam int APB_DATA_WIDTH = 32;
    localparam int APB_ADDR_WIDTH = 8;

    typedef logic [1:0] apb_state_t;

    localparam apb_state_t ST_IDLE   = 2'd0;
    localparam apb_state_t ST_SETUP  = 2'd1;
    localparam apb_state_t ST_ACCESS = 2'd2;

    function automatic int rr_slot(input int last, input int offset, input int n);
        return (last + offset) % n;
    endfunction

endpackage

// File: rtl/apb3_master_arbiter_if.sv
// Request-side and APB-side signal bundle for the shared APB3 master.
// Wires only, no latency. Requests use valid/ready; APB completion uses PREADY.
// The master modport is the arbiter; the slave modport is the client/fabric side.
interface apb3_master_arbiter_if
    import apb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = APB_DATA_WIDTH,
    parameter int ADDR_WIDTH = APB_ADDR_WIDTH
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_write;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0]         rsp_rdata;
    logic                          rsp_err;

    logic [ADDR_WIDTH-1:0]         PADDR;
    logic                          PSEL;
    logic                          PENABLE;
    logic                          PWRITE;
    logic [DATA_WIDTH-1:0]         PWDATA;
    logic [DATA_WIDTH-1:0]         PRDATA;
    logic                          PREADY;
    logic                          PSLVERR;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY, PSLVERR,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, PADDR, PSEL, PENABLE, PWRITE, PWDATA
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY, PSLVERR,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, PADDR, PSEL, PENABLE, PWRITE, PWDATA
    );

endinterface

// File: rtl/apb_rr_arbiter.sv
// Round-robin grant: first valid requester searching upward (with wrap) from last grant + 1.
// Combinational, zero latency. No backpressure; caller decides when to consume the grant.
module apb_rr_arbiter
    import apb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req_valid,
    input  logic [IDX_W-1:0]   i_last_grant,
    output logic [NUM_REQ-1:0] o_grant_oh,
    output logic [IDX_W-1:0]   o_grant_idx,
    output logic               o_any
);

    logic [IDX_W-1:0] w_cand;

    always_comb begin
        o_grant_oh  = '0;
        o_grant_idx = '0;
        o_any       = 1'b0;
        w_cand      = '0;
        // Walk from the farthest slot down so the nearest valid slot wins.
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_cand = IDX_W'(rr_slot(int'(i_last_grant), k, NUM_REQ));
            if (i_req_valid[w_cand]) begin
                o_grant_idx = w_cand;
                o_any       = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (o_any && (o_grant_idx == IDX_W'(i))) begin
                o_grant_oh[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb3_master_arbiter.sv
// Shares one APB3 bus among NUM_REQ requesters with round-robin arbitration and a PREADY watchdog.
// Latency: req_ready 1 cycle after sampling, rsp_valid 3 cycles after sampling plus PREADY wait states.
// Backpressure: requests wait until granted; APB slave stalls via PREADY, aborted after TIMEOUT cycles.
module apb3_master_arbiter
    import apb_pkg::*;
#(
    parameter int DATA_WIDTH = APB_DATA_WIDTH,
    parameter int ADDR_WIDTH = APB_ADDR_WIDTH,
    parameter int NUM_REQ    = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,
    apb3_master_arbiter_if.master bus
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    apb_state_t              r_state;
    logic [IDX_W-1:0]        r_last_grant;
    logic [NUM_REQ-1:0]      r_gnt_oh;
    logic                    r_psel;
    logic                    r_penable;
    logic                    r_pwrite;
    logic [ADDR_WIDTH-1:0]   r_paddr;
    logic [DATA_WIDTH-1:0]   r_pwdata;
    logic [NUM_REQ-1:0]      r_req_ready;
    logic [NUM_REQ-1:0]      r_rsp_valid;
    logic [DATA_WIDTH-1:0]   r_rsp_rdata;
    logic                    r_rsp_err;
    logic [CNT_W-1:0]        r_wait_cnt;

    logic [NUM_REQ-1:0]      w_grant_oh;
    logic [IDX_W-1:0]        w_grant_idx;
    logic                    w_any;
    logic [ADDR_WIDTH-1:0]   w_sel_addr;
    logic [DATA_WIDTH-1:0]   w_sel_wdata;
    logic                    w_sel_write;
    logic                    w_timeout;

    apb_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .i_req_valid  (bus.req_valid),
        .i_last_grant (r_last_grant),
        .o_grant_oh   (w_grant_oh),
        .o_grant_idx  (w_grant_idx),
        .o_any        (w_any)
    );

    always_comb begin
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_write = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant_idx == IDX_W'(i)) begin
                w_sel_addr  = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_wdata = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                w_sel_write = bus.req_write[i];
            end
        end
    end

    // PREADY is checked first, so a completion on the final allowed cycle still wins.
    assign w_timeout = (TIMEOUT != 0) && (r_wait_cnt == TMO_LAST);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state      <= ST_IDLE;
            r_last_grant <= IDX_W'(NUM_REQ - 1);
            r_gnt_oh     <= '0;
            r_psel       <= 1'b0;
            r_penable    <= 1'b0;
            r_pwrite     <= 1'b0;
            r_paddr      <= '0;
            r_pwdata     <= '0;
            r_req_ready  <= '0;
            r_rsp_valid  <= '0;
            r_rsp_rdata  <= '0;
            r_rsp_err    <= 1'b0;
            r_wait_cnt   <= '0;
        end else begin
            r_req_ready <= '0;
            r_rsp_valid <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_state      <= ST_SETUP;
                        r_gnt_oh     <= w_grant_oh;
                        r_last_grant <= w_grant_idx;
                        r_paddr      <= w_sel_addr;
                        r_pwrite     <= w_sel_write;
                        r_pwdata     <= w_sel_write ? w_sel_wdata : '0;
                        r_psel       <= 1'b1;
                        r_req_ready  <= w_grant_oh;
                    end
                end
                ST_SETUP: begin
                    r_state    <= ST_ACCESS;
                    r_penable  <= 1'b1;
                    r_wait_cnt <= '0;
                end
                ST_ACCESS: begin
                    if (bus.PREADY) begin
                        r_state     <= ST_IDLE;
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_rsp_valid <= r_gnt_oh;
                        r_rsp_rdata <= r_pwrite ? '0 : bus.PRDATA;
                        r_rsp_err   <= bus.PSLVERR;
                    end else if (w_timeout) begin
                        r_state     <= ST_IDLE;
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_rsp_valid <= r_gnt_oh;
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                end
            endcase
        end
    end

    assign bus.PSEL      = r_psel;
    assign bus.PENABLE   = r_penable;
    assign bus.PWRITE    = r_pwrite;
    assign bus.PADDR     = r_paddr;
    assign bus.PWDATA    = r_pwdata;
    assign bus.req_ready = r_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_apb3_master_arbiter.sv
// Directed bench for the shared APB3 master: behavioural slave, response scoreboard, timing probes.
module tb_apb3_master_arbiter;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int AW = 8;
    localparam int TMO = 16;

    logic PCLK = 1'b0;
    logic PRESETn = 1'b0;
    always #5 PCLK = ~PCLK;

    apb3_master_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    apb3_master_arbiter #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_REQ    (NR),
        .TIMEOUT    (TMO)
    ) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .bus     (bus)
    );

    typedef struct {
        int          idx;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t        exp_q[$];
    int          acc_log[$];
    int          setup_cyc[$];
    logic [3:0]  setup_rdy[$];

    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          acc_cnt = 0;
    int          slave_waits = 0;
    logic [31:0] slave_rdata = 32'h55AA55AA;
    logic        slave_err = 1'b0;
    logic [7:0]  stuck_addr = 8'hFF;

    always @(posedge PCLK) cyc++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Slave model and response monitor share one process so their ordering is fixed.
    always @(negedge PCLK) begin
        logic rdy;
        if (bus.PSEL && bus.PENABLE) begin
            rdy = (bus.PADDR != stuck_addr) && (acc_cnt >= slave_waits);
            bus.PREADY  = rdy;
            bus.PRDATA  = rdy ? slave_rdata : 32'hBAD0BAD0;
            bus.PSLVERR = rdy & slave_err;
            acc_cnt++;
        end else begin
            bus.PREADY  = 1'b0;
            bus.PSLVERR = 1'b0;
            bus.PRDATA  = 32'hBAD0BAD0;
            if (acc_cnt != 0) begin
                acc_log.push_back(acc_cnt);
                acc_cnt = 0;
            end
        end
        if (bus.PSEL && !bus.PENABLE) begin
            setup_cyc.push_back(cyc);
            setup_rdy.push_back(bus.req_ready);
        end
        if (bus.rsp_valid != '0) begin
            check("rsp_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("rsp_valid_onehot", 64'(bus.rsp_valid), 64'd1 << e.idx);
                check("rsp_err", 64'(bus.rsp_err), 64'(e.err));
                check("rsp_rdata", 64'(bus.rsp_rdata), 64'(e.rdata));
            end
        end
    end

    task automatic raise(input int r, input logic wr, input logic [7:0] a, input logic [31:0] d);
        bus.req_valid[r]           = 1'b1;
        bus.req_write[r]           = wr;
        bus.req_addr[r*AW +: AW]   = a;
        bus.req_wdata[r*DW +: DW]  = d;
    endtask

    task automatic push_exp(input int idx, input logic err, input logic [31:0] rdata);
        exp_t e;
        e.idx = idx; e.err = err; e.rdata = rdata;
        exp_q.push_back(e);
    endtask

    task automatic wait_ready(input int r);
        int n = 0;
        while (!bus.req_ready[r] && n < 100) begin
            @(negedge PCLK);
            n++;
        end
        check("req_ready_seen", 64'(n < 100), 64'd1);
        bus.req_valid[r] = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge PCLK);
            n++;
        end
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        @(negedge PCLK);
    endtask

    initial begin : global_watchdog
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int order[8];
        int last;
        int n;

        bus.req_valid = '0;
        bus.req_write = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;

        // Reset state
        repeat (3) @(negedge PCLK);
        check("rst_psel_pen_pwr", 64'({bus.PSEL, bus.PENABLE, bus.PWRITE}), 64'd0);
        check("rst_paddr_pwdata", 64'({bus.PADDR, bus.PWDATA}), 64'd0);
        check("rst_rsp", 64'({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}), 64'd0);
        PRESETn = 1'b1;
        @(negedge PCLK);

        // Single write, zero-wait, cycle-exact
        raise(0, 1'b1, 8'h04, 32'hDEADBEEF);
        push_exp(0, 1'b0, 32'h0);
        @(negedge PCLK);
        check("w_setup_ready", 64'(bus.req_ready), 64'b0001);
        check("w_setup_psel_pen", 64'({bus.PSEL, bus.PENABLE}), 64'b10);
        check("w_setup_addr_wr", 64'({bus.PADDR, bus.PWRITE}), 64'h009);
        check("w_setup_pwdata", 64'(bus.PWDATA), 64'hDEADBEEF);
        bus.req_valid[0] = 1'b0;
        @(negedge PCLK);
        check("w_access_psel_pen", 64'({bus.PSEL, bus.PENABLE}), 64'b11);
        check("w_access_ready_low", 64'(bus.req_ready), 64'd0);
        check("w_access_addr", 64'(bus.PADDR), 64'h04);
        @(negedge PCLK);
        check("w_done_rsp_valid", 64'(bus.rsp_valid), 64'b0001);
        check("w_done_psel", 64'(bus.PSEL), 64'd0);
        wait_drain();

        // Read with two wait states
        slave_waits = 2;
        slave_rdata = 32'h12345678;
        acc_log.delete();
        push_exp(2, 1'b0, 32'h12345678);
        raise(2, 1'b0, 8'h08, 32'hFFFFFFFF);
        wait_ready(2);
        check("r_setup_addr_wr", 64'({bus.PADDR, bus.PWRITE}), 64'h010);
        check("r_setup_pwdata_zero", 64'(bus.PWDATA), 64'd0);
        wait_drain();
        check("r_access_len", 64'((acc_log.size() > 0) ? acc_log[0] : -1), 64'd3);

        // Round-robin with all requesters held high; last grant is 2
        slave_waits = 0;
        setup_cyc.delete();
        setup_rdy.delete();
        last = 2;
        for (int k = 0; k < 8; k++) begin
            last = (last + 1) % NR;
            order[k] = last;
            push_exp(last, 1'b0, 32'h0);
        end
        for (int i = 0; i < NR; i++) raise(i, 1'b1, 8'h40 + 8'(i), 32'h1000 + i);
        n = 0;
        while (setup_cyc.size() < 8 && n < 200) begin
            @(negedge PCLK);
            n++;
        end
        check("rr_setups_seen", 64'(setup_cyc.size() >= 8), 64'd1);
        bus.req_valid = '0;
        wait_drain();
        for (int k = 0; k < 8; k++) begin
            if (k < setup_rdy.size()) check("rr_grant_order", 64'(setup_rdy[k]), 64'd1 << order[k]);
            if (k > 0 && k < setup_cyc.size())
                check("rr_setup_period", 64'(setup_cyc[k] - setup_cyc[k-1]), 64'd3);
        end

        // Slave error, then clean transfer; last grant is 2
        slave_err   = 1'b1;
        slave_rdata = 32'hA5A5A5A5;
        push_exp(1, 1'b1, 32'hA5A5A5A5);
        raise(1, 1'b0, 8'h10, 32'h0);
        wait_ready(1);
        wait_drain();
        check("err_hold", 64'(bus.rsp_err), 64'd1);
        slave_err   = 1'b0;
        slave_rdata = 32'h0F0F0F0F;
        push_exp(3, 1'b0, 32'h0);
        raise(3, 1'b1, 8'h14, 32'hCAFEF00D);
        wait_ready(3);
        wait_drain();

        // Watchdog abort on a stuck slave, then the pending request proceeds
        stuck_addr  = 8'h20;
        slave_rdata = 32'h13572468;
        acc_log.delete();
        push_exp(0, 1'b1, 32'h0);
        push_exp(1, 1'b0, 32'h13572468);
        raise(0, 1'b0, 8'h20, 32'h0);
        raise(1, 1'b0, 8'h24, 32'h0);
        wait_ready(0);
        wait_ready(1);
        wait_drain();
        check("tmo_access_len", 64'((acc_log.size() > 0) ? acc_log[0] : -1), 64'd16);
        check("tmo_next_len", 64'((acc_log.size() > 1) ? acc_log[1] : -1), 64'd1);

        // Reset in the middle of ACCESS wait states
        stuck_addr = 8'h30;
        raise(2, 1'b0, 8'h30, 32'h0);
        wait_ready(2);
        repeat (4) @(negedge PCLK);
        check("mid_access_active", 64'({bus.PSEL, bus.PENABLE}), 64'b11);
        raise(3, 1'b0, 8'h34, 32'h0);
        raise(0, 1'b0, 8'h38, 32'h0);
        #2 PRESETn = 1'b0;
        #1;
        check("arst_psel_pen_pwr", 64'({bus.PSEL, bus.PENABLE, bus.PWRITE}), 64'd0);
        check("arst_paddr_pwdata", 64'({bus.PADDR, bus.PWDATA}), 64'd0);
        check("arst_rsp", 64'({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}), 64'd0);
        @(negedge PCLK);
        stuck_addr  = 8'hFF;
        slave_rdata = 32'h24681357;
        setup_rdy.delete();
        push_exp(0, 1'b0, 32'h24681357);
        push_exp(3, 1'b0, 32'h24681357);
        PRESETn = 1'b1;
        wait_ready(0);
        wait_ready(3);
        wait_drain();
        check("post_rst_first", 64'((setup_rdy.size() > 0) ? setup_rdy[0] : 4'hF), 64'b0001);
        check("post_rst_second", 64'((setup_rdy.size() > 1) ? setup_rdy[1] : 4'hF), 64'b1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/apb3_master_arbiter.md
# apb3_master_arbiter

Sequences and shares a single APB3 bus among NUM_REQ local requesters. It arbitrates requests round-robin and drives the APB SETUP/ACCESS phases toward the peripheral register slaves. It waits on PREADY, with a watchdog timeout, and returns read data and error status to the granted requester. It sits between internal bus clients (DMA, CPU bridge, debug port) and the APB slave fabric.

## Interface
- DATA_WIDTH, 32, data bus width
- ADDR_WIDTH, 8, APB address width
- NUM_REQ, 4, number of requesters (≥2)
- TIMEOUT, 16, max consecutive ACCESS cycles with PREADY low; 0 disables watchdog

Ports:
- PCLK  in  1  clock; one clock domain only
- PRESETn  in  1  reset; asynchronous, active-low
- req_valid  in  NUM_REQ  per-requester request; held high until req_ready
- req_write  in  NUM_REQ  1=write, 0=read
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data
- req_ready  out  NUM_REQ  one-hot, one-cycle accept pulse
- rsp_valid  out  NUM_REQ  one-hot, one-cycle completion pulse
- rsp_rdata  out  DATA_WIDTH  read data; qualified by rsp_valid
- rsp_err  out  1  error; qualified by rsp_valid
- PADDR  out  ADDR_WIDTH  APB address
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction
- PWDATA  out  DATA_WIDTH  APB write data
- PRDATA  in  DATA_WIDTH  APB read data
- PREADY  in  1  APB ready
- PSLVERR  in  1  APB slave error

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: if any req_valid, grant g = first set bit searching upward (with wrap) from last_grant+1. Latch req_addr[g], req_write[g], and req_wdata[g] (0 for reads). Go to SETUP. Otherwise stay in IDLE.
- SETUP: PSEL=1, PENABLE=0, req_ready[g]=1. Always go to ACCESS.
- ACCESS: PSEL=1, PENABLE=1.
  - PREADY=1: capture PRDATA (0 for writes) and PSLVERR. Go to IDLE; the next cycle drives rsp_valid[g]=1.
  - PREADY=0: increment the wait counter.
  - Wait counter reaches TIMEOUT (TIMEOUT≠0): abort. rsp_err=1, rsp_rdata=0, go to IDLE.
- last_grant updates to g on entry to SETUP. It resets to NUM_REQ-1, so requester 0 wins first.
- PADDR, PWRITE and PWDATA are stable from SETUP through the end of ACCESS. They hold their last values in IDLE.
- Requests not granted remain pending. No requester is starved: worst-case wait is NUM_REQ-1 transfers.
- req_valid dropped before grant: the request is withdrawn, with no side effects.
- Reset (asserted anytime, including mid-transfer): state → IDLE. All outputs go to 0 immediately: PSEL, PENABLE, PWRITE, PADDR, PWDATA, req_ready, rsp_valid, rsp_rdata, rsp_err. The wait counter clears. No response is issued for the dropped transfer.

## Timing
- All outputs are registered; no combinational input→output paths.
- Request sampled in IDLE at cycle N: SETUP in N+1 (req_ready pulse), ACCESS from N+2.
- Zero-wait slave: rsp_valid in N+3, with IDLE in the same cycle. The next SETUP is no earlier than N+4, so the minimum transfer period is 3 cycles.
- Each PREADY-low cycle in ACCESS adds 1 cycle.
- Timeout: after TIMEOUT consecutive PREADY-low ACCESS cycles, the FSM leaves ACCESS at the next edge. PSEL drops and rsp_valid/rsp_err pulse.
- PREADY=1 on the cycle the counter reaches TIMEOUT: normal completion wins.
- rsp_rdata and rsp_err hold their values until the next completion.

## Structure
- Shared package apb_pkg holds:
  - the state typedef (IDLE/SETUP/ACCESS)
  - APB width defaults (DATA_WIDTH, ADDR_WIDTH), shared with the register slave
- Sub-module apb_rr_arbiter: combinational round-robin grant from req_valid and last_grant. Outputs are a one-hot grant and the grant index.
- The FSM, latches, watchdog counter and response registers stay in the top module.

## Test plan
- Single write: req 0 writes 0xDEADBEEF to 0x04, zero-wait slave → req_ready[0] in N+1. APB shows PSEL/PENABLE in N+1/N+2 with PADDR=0x04, PWRITE=1. rsp_valid[0] in N+3, rsp_err=0.
- Read with waits: req 2 reads 0x08, slave holds PREADY low 2 cycles, PRDATA=0x12345678 → ACCESS lasts 3 cycles. rsp_valid[2] with rsp_rdata=0x12345678.
- Round-robin: all four req_valid held high continuously → grant order 0,1,2,3,0,…; each req_ready is one-hot, and there are exactly 3 cycles between SETUPs.
- Slave error: PSLVERR=1 with PREADY → rsp_err=1 for that requester only; the next transfer has rsp_err=0.
- Timeout: TIMEOUT=16, PREADY stuck low → PSEL deasserts after 16 ACCESS cycles. rsp_valid with rsp_err=1 and rsp_rdata=0, then the next pending request proceeds.
- Reset mid-ACCESS: PRESETn low during wait states → all outputs 0 in the same cycle, with no rsp_valid. After release, requester 0 is granted first.
